logicnet_input_quantizer: RTL and testbench
===========================================

Name: logicnet_input_quantizer

Overview:
- Streaming front end that sits directly upstream of the layer-0 LUT neurons.
- Accepts one raw feature word per handshake, in feature-index order.
- Quantizes each word to IN_BITS using per-feature thresholds and assembles the full layer-0 input bus.
- Presents the bus to the layer-0 fabric through a registered valid/ready output slot, so sample n+1 can be collected while sample n is held.

Parameters:
- NUM_FEATURES, 16, features per sample.
- FEAT_W, 8, raw feature width, unsigned.
- IN_BITS, 2, quantized code width per feature. The number of thresholds is 2^IN_BITS-1.
- THRESH, all-zero packed vector, NUM_FEATURES*(2^IN_BITS-1)*FEAT_W bits. Threshold j of feature i sits at offset ((i*(2^IN_BITS-1))+j)*FEAT_W. Thresholds are ascending per feature.
- CNT_W, $clog2(NUM_FEATURES), feature index counter width.

Ports:
- clk, input, 1, single clock; all logic is rising-edge.
- rst, input, 1, synchronous, active-high reset.
- s_valid, input, 1, raw feature word valid.
- s_ready, output, 1, block can accept a feature.
- s_data, input, FEAT_W, raw feature value.
- s_last, input, 1, marks the final feature of a sample.
- m_valid, output, 1, quantized sample valid.
- m_ready, input, 1, layer-0 consumer accepts the sample.
- m_data, output, NUM_FEATURES*IN_BITS, quantized input bus. Feature i occupies [i*IN_BITS +: IN_BITS].
- err_pulse, output, 1, one-cycle framing error indication.

Behaviour:
- Quantization (combinational, per accepted word): code = number of feature-i thresholds satisfying s_data >= T[j]. Range 0..2^IN_BITS-1, saturating. Comparisons are unsigned, FEAT_W wide.
- An accept happens on any cycle with s_valid & s_ready. The code is written into the assembly register at slot idx, then idx increments.
- FSM states:
  - COLLECT: s_ready=1.
  - HOLD: assembly register is complete but the output slot is occupied; s_ready=0.
- COLLECT, accept with idx==NUM_FEATURES-1 and s_last=1:
  - If the output slot is empty, or m_ready=1 that cycle, the assembly register, including the final code, moves to m_data on the same edge. m_valid=1 next cycle, idx=0, state stays COLLECT.
  - Otherwise go to HOLD.
- HOLD: when m_valid & m_ready, the assembled sample loads into m_data on that edge, m_valid stays 1, idx=0, next state is COLLECT.
- Framing errors:
  - Early last: s_last=1 with idx<NUM_FEATURES-1.
  - Missing last: idx==NUM_FEATURES-1 with s_last=0.
  - On either error the partial sample is discarded, idx=0, err_pulse=1 for one cycle, and the word is consumed. The output slot is unaffected.
- Output slot:
  - m_data is stable while m_valid & !m_ready.
  - m_valid clears on a handshake with no new sample loading.
  - Simultaneous handshake and load gives back-to-back samples with no bubble.
- Latency: final feature accepted at edge k gives m_valid=1 after edge k when the slot is free. Throughput is one feature per cycle sustained.
- Reset (synchronous, priority over all else):
  - State COLLECT, idx=0, assembly register 0.
  - m_valid=0, m_data=0, err_pulse=0.
  - s_ready=1 from the first cycle after reset deasserts.
  - Reset asserted mid-sample drops the partial sample silently, with no err_pulse.
- No combinational path from m_ready to s_ready other than through the FSM state. s_ready is a function of state only.

Decomposition:
- Shared package logicnet_pkg holds:
  - localparams for IN_BITS, FEAT_W and NUM_FEATURES defaults.
  - The threshold-count function NUM_THR(IN_BITS)=2^IN_BITS-1.
  - The FSM state enum {COLLECT, HOLD}.
- One sub-module, feature_threshold_cmp. It is purely combinational:
  - Inputs: feature value and the selected threshold slice.
  - Output: the IN_BITS code.
  - Threshold selection by idx is a mux in the parent.

Test Plan (bench uses NUM_FEATURES=4, FEAT_W=8, IN_BITS=2, thresholds 64/128/192 for every feature):
- Reset then stream 10,64,150,255 with s_last on the 4th, m_ready=1 -> m_data=8'b11_10_01_00 and m_valid=1 for exactly one cycle after the 4th edge; err_pulse stays 0.
- Boundary values 63,127,191,192 -> codes 0,1,2,3, so m_data=8'b11_10_01_00.
- m_ready held 0, stream two full samples back to back:
  - Sample 1 is held stable.
  - s_ready drops to 0 in HOLD after the 8th word.
  - Raising m_ready gives sample 2 on the next cycle with m_valid continuously 1.
- s_last asserted on the 2nd word -> err_pulse=1 one cycle, no m_valid; the next clean 4-word sample outputs correctly.
- 4th word with s_last=0 -> err_pulse=1, sample dropped, idx returns to 0.
- Assert rst after 2 words, then send a full sample -> no err_pulse; output reflects only the post-reset sample; m_valid=0 and m_data=0 during reset.

Source files
------------

// File: rtl/logicnet_pkg.sv
`default_nettype none
// ============================================================================
// Module   : logicnet_pkg
// Purpose  : Shared defaults, threshold-count helper and FSM encoding for the
//            LogicNet input quantizer.
// Revision : 1.0
// ============================================================================
package logicnet_pkg;

    localparam int DEF_NUM_FEATURES = 16;
    localparam int DEF_FEAT_W       = 8;
    localparam int DEF_IN_BITS      = 2;

    function automatic int NUM_THR(input int in_bits);
        return (1 << in_bits) - 1;
    endfunction

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

endpackage : logicnet_pkg
`default_nettype wire

// File: rtl/logicnet_input_quantizer_feature_threshold_cmp.sv
`default_nettype none
// ============================================================================
// Module   : feature_threshold_cmp
// Purpose  : Thermometer-to-count quantizer; code is the number of thresholds
//            the feature meets or exceeds (unsigned compare).
// Revision : 1.0
// ============================================================================
module feature_threshold_cmp
    import logicnet_pkg::*;
#(
    parameter int FEAT_W  = DEF_FEAT_W,
    parameter int IN_BITS = DEF_IN_BITS,
    localparam int NTHR   = NUM_THR(IN_BITS)
) (
    input  logic [FEAT_W-1:0]      feature,
    input  logic [NTHR*FEAT_W-1:0] thresholds,
    output logic [IN_BITS-1:0]     code
);

    always_comb begin
        code = '0;
        for (int j = 0; j < NTHR; j++) begin
            if (feature >= thresholds[j*FEAT_W +: FEAT_W]) begin
                code = code + IN_BITS'(1);
            end
        end
    end

endmodule : feature_threshold_cmp
`default_nettype wire

// File: rtl/logicnet_input_quantizer.sv
`default_nettype none
// ============================================================================
// Module   : logicnet_input_quantizer
// Purpose  : Streams raw feature words, quantizes them against per-feature
//            thresholds and presents the assembled layer-0 bus on a
//            registered valid/ready slot.
// Revision : 1.0
// ============================================================================
module logicnet_input_quantizer
    import logicnet_pkg::*;
#(
    parameter int NUM_FEATURES = DEF_NUM_FEATURES,
    parameter int FEAT_W       = DEF_FEAT_W,
    parameter int IN_BITS      = DEF_IN_BITS,
    parameter logic [NUM_FEATURES*NUM_THR(IN_BITS)*FEAT_W-1:0] THRESH = '0,
    parameter int CNT_W        = $clog2(NUM_FEATURES)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [FEAT_W-1:0]               s_data,
    input  logic                            s_last,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [NUM_FEATURES*IN_BITS-1:0] m_data,
    output logic                            err_pulse
);

    localparam int NTHR    = NUM_THR(IN_BITS);
    localparam int SLICE_W = NTHR * FEAT_W;
    localparam int BUS_W   = NUM_FEATURES * IN_BITS;

    state_e                 r_state;
    logic [CNT_W-1:0]       r_idx;
    logic [BUS_W-1:0]       r_asm;

    logic [SLICE_W-1:0]     w_thr_sel;
    logic [IN_BITS-1:0]     w_code;
    logic [BUS_W-1:0]       w_asm_full;
    logic                   w_accept;
    logic                   w_is_last_idx;
    logic                   w_err;
    logic                   w_complete;
    logic                   w_slot_free;

    // s_ready depends on state only, keeping m_ready off the input path.
    assign s_ready       = (r_state == COLLECT);
    assign w_accept      = s_valid & s_ready;
    assign w_is_last_idx = (r_idx == CNT_W'(NUM_FEATURES - 1));
    assign w_err         = w_accept & (s_last ^ w_is_last_idx);
    assign w_complete    = w_accept & s_last & w_is_last_idx;
    assign w_slot_free   = ~m_valid | m_ready;

    always_comb begin
        w_thr_sel = '0;
        for (int i = 0; i < NUM_FEATURES; i++) begin
            if (r_idx == CNT_W'(i)) begin
                w_thr_sel = THRESH[i*SLICE_W +: SLICE_W];
            end
        end
    end

    feature_threshold_cmp #(
        .FEAT_W  (FEAT_W),
        .IN_BITS (IN_BITS)
    ) u_cmp (
        .feature    (s_data),
        .thresholds (w_thr_sel),
        .code       (w_code)
    );

    always_comb begin
        w_asm_full = r_asm;
        for (int i = 0; i < NUM_FEATURES; i++) begin
            if (r_idx == CNT_W'(i)) begin
                w_asm_full[i*IN_BITS +: IN_BITS] = w_code;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= COLLECT;
            r_idx     <= '0;
            r_asm     <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= w_err;

            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        if (w_err) begin
                            r_idx <= '0;
                            r_asm <= '0;
                        end else if (w_complete) begin
                            r_idx <= '0;
                            if (w_slot_free) begin
                                m_data  <= w_asm_full;
                                m_valid <= 1'b1;
                                r_asm   <= '0;
                            end else begin
                                r_asm   <= w_asm_full;
                                r_state <= HOLD;
                            end
                        end else begin
                            r_asm <= w_asm_full;
                            r_idx <= r_idx + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (m_valid && m_ready) begin
                        m_data  <= r_asm;
                        m_valid <= 1'b1;
                        r_asm   <= '0;
                        r_idx   <= '0;
                        r_state <= COLLECT;
                    end
                end
                default: begin
                    r_state <= COLLECT;
                end
            endcase
        end
    end

endmodule : logicnet_input_quantizer
`default_nettype wire

// File: tb/tb_logicnet_input_quantizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_logicnet_input_quantizer
// Purpose  : Directed scoreboard bench for logicnet_input_quantizer.
// Revision : 1.0
// ============================================================================
module tb_logicnet_input_quantizer;

    localparam int NF = 4;
    localparam int FW = 8;
    localparam int IB = 2;
    localparam logic [NF*3*FW-1:0] THR = {NF{8'd192, 8'd128, 8'd64}};

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [FW-1:0] s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [NF*IB-1:0] m_data;
    logic          err_pulse;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int err_seen = 0;
    logic [7:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;

    logicnet_input_quantizer #(
        .NUM_FEATURES (NF),
        .FEAT_W       (FW),
        .IN_BITS      (IB),
        .THRESH       (THR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .err_pulse (err_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] q(input logic [7:0] v);
        if (v >= 8'd192) return 2'd3;
        if (v >= 8'd128) return 2'd2;
        if (v >= 8'd64)  return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [7:0] pack4(input logic [7:0] a, b, c, d);
        return {q(d), q(c), q(b), q(a)};
    endfunction

    // Output monitor: pops the scoreboard on each handshake, checks hold stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (err_pulse) err_seen++;
            if (prev_stall) chk("hold_stable", 32'(m_data), 32'(prev_data));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(m_valid), 32'(0));
                end else begin
                    chk("out_data", 32'(m_data), 32'(exp_q.pop_front()));
                end
            end
            prev_stall <= m_valid & ~m_ready;
            prev_data  <= m_data;
        end
    end

    // Drive a word, wait (bounded) for it to be accepted; returns at posedge+1.
    task automatic send(input logic [7:0] d, input logic l);
        bit done = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            done = s_ready;
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        idle(3);
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_m_data", 32'(m_data), 32'(0));
        chk("rst_err", 32'(err_pulse), 32'(0));
        rst = 1'b0;
        idle(1);
        chk("post_rst_s_ready", 32'(s_ready), 32'(1));

        // Basic sample, m_ready held high
        exp_q.push_back(pack4(8'd10, 8'd64, 8'd150, 8'd255));
        send(8'd10, 0); send(8'd64, 0); send(8'd150, 0); send(8'd255, 1);
        chk("basic_valid", 32'(m_valid), 32'(1));
        chk("basic_data", 32'(m_data), 32'(8'b11_10_01_00));
        chk("basic_err", 32'(err_pulse), 32'(0));
        idle(1);
        chk("basic_valid_1cyc", 32'(m_valid), 32'(0));

        // Threshold boundaries
        exp_q.push_back(pack4(8'd63, 8'd127, 8'd191, 8'd192));
        send(8'd63, 0); send(8'd127, 0); send(8'd191, 0); send(8'd192, 1);
        chk("bound_data", 32'(m_data), 32'(8'b11_10_01_00));
        idle(2);

        // Back-pressure: two samples back to back with m_ready low
        m_ready = 1'b0;
        exp_q.push_back(pack4(8'd200, 8'd100, 8'd70, 8'd0));
        exp_q.push_back(pack4(8'd5, 8'd130, 8'd199, 8'd64));
        send(8'd200, 0); send(8'd100, 0); send(8'd70, 0); send(8'd0, 1);
        chk("bp_s1_valid", 32'(m_valid), 32'(1));
        chk("bp_s1_data", 32'(m_data), 32'(pack4(8'd200, 8'd100, 8'd70, 8'd0)));
        send(8'd5, 0); send(8'd130, 0); send(8'd199, 0); send(8'd64, 1);
        chk("bp_hold_s_ready", 32'(s_ready), 32'(0));
        chk("bp_hold_s1_data", 32'(m_data), 32'(pack4(8'd200, 8'd100, 8'd70, 8'd0)));
        idle(3);
        chk("bp_still_hold", 32'(s_ready), 32'(0));
        m_ready = 1'b1;
        idle(1);
        chk("bp_s2_valid", 32'(m_valid), 32'(1));
        chk("bp_s2_data", 32'(m_data), 32'(pack4(8'd5, 8'd130, 8'd199, 8'd64)));
        chk("bp_collect_s_ready", 32'(s_ready), 32'(1));
        idle(1);
        chk("bp_drained", 32'(m_valid), 32'(0));

        // Early last on 2nd word
        send(8'd90, 0); send(8'd90, 1);
        chk("early_err", 32'(err_pulse), 32'(1));
        chk("early_no_valid", 32'(m_valid), 32'(0));
        idle(1);
        chk("early_err_1cyc", 32'(err_pulse), 32'(0));
        exp_q.push_back(pack4(8'd255, 8'd0, 8'd128, 8'd64));
        send(8'd255, 0); send(8'd0, 0); send(8'd128, 0); send(8'd64, 1);
        chk("early_recover", 32'(m_data), 32'(pack4(8'd255, 8'd0, 8'd128, 8'd64)));
        idle(2);

        // Missing last on 4th word
        send(8'd1, 0); send(8'd2, 0); send(8'd3, 0); send(8'd4, 0);
        chk("miss_err", 32'(err_pulse), 32'(1));
        chk("miss_no_valid", 32'(m_valid), 32'(0));
        exp_q.push_back(pack4(8'd64, 8'd192, 8'd10, 8'd130));
        send(8'd64, 0); send(8'd192, 0); send(8'd10, 0); send(8'd130, 1);
        chk("miss_recover_err", 32'(err_pulse), 32'(0));
        chk("miss_recover", 32'(m_data), 32'(pack4(8'd64, 8'd192, 8'd10, 8'd130)));
        idle(2);

        // Reset mid-sample
        send(8'd250, 0); send(8'd250, 0);
        s_valid = 1'b0;
        rst = 1'b1;
        idle(2);
        chk("midrst_m_valid", 32'(m_valid), 32'(0));
        chk("midrst_m_data", 32'(m_data), 32'(0));
        rst = 1'b0;
        idle(1);
        exp_q.push_back(pack4(8'd0, 8'd70, 8'd140, 8'd210));
        send(8'd0, 0);
        chk("midrst_err0", 32'(err_pulse), 32'(0));
        send(8'd70, 0);
        chk("midrst_err1", 32'(err_pulse), 32'(0));
        send(8'd140, 0);
        send(8'd210, 1);
        chk("midrst_err3", 32'(err_pulse), 32'(0));
        chk("midrst_data", 32'(m_data), 32'(pack4(8'd0, 8'd70, 8'd140, 8'd210)));
        idle(3);

        chk("err_total", 32'(err_seen), 32'(2));
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_logicnet_input_quantizer
`default_nettype wire
